vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA controller: generates hsync/vsync/blank and a linear frame-buffer address from fully parametrised timing.
Adds:
- a pixel clock-enable, so the core runs from a faster system clock;
- power-of-two pixel replication, so a smaller frame buffer fills the screen;
- sync-polarity parameters;
- a parametrised memory-latency delay line, so sync/blank stay aligned with returned pixel data.

Sits between the system clock and the frame-buffer RAM / DAC.

Parameters:
HRES, 640, visible pixels per line
HFRONT, 16, h front porch (pixels)
HSYNC, 96, h sync width
HBACK, 48, h back porch
VRES, 480, visible lines
VFRONT, 10, v front porch (lines)
VSYNC, 2, v sync width
VBACK, 33, v back porch
HSYNC_POL, 0, active level of vga_hsync (0 = active-low)
VSYNC_POL, 0, active level of vga_vsync
HSCALE, 0, log2 horizontal replication (0..3)
VSCALE, 0, log2 vertical replication (0..3)
MEM_LAT, 1, frame-buffer read latency in pixel slots (0..4)
ADDR_W, 19, width of mem_add

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_ce  in  1  pixel-slot enable; all state advances only when high
mem_add  out  ADDR_W  frame-buffer read address
vga_hsync  out  1  horizontal sync, polarity HSYNC_POL, delayed MEM_LAT slots
vga_vsync  out  1  vertical sync, polarity VSYNC_POL, delayed MEM_LAT slots
vga_blank  out  1  1 = visible pixel, 0 = blanked, delayed MEM_LAT slots
vga_sync  out  1  tied 0 (sync-on-green off)
line_start  out  1  one-cycle pulse, undelayed, when hcount wraps to 0
frame_start  out  1  one-cycle pulse, undelayed, when hcount = 0 and vcount = 0

Behaviour:
Totals:
- HTOTAL = HRES+HFRONT+HSYNC+HBACK; VTOTAL likewise.

Counters (advance only on clock edges with pix_ce = 1; otherwise every register holds):
- hcount runs 0..HTOTAL-1 and wraps to 0.
- vcount increments on the h wrap; it runs 0..VTOTAL-1 and wraps to 0.
- No off-by-one: a line is exactly HTOTAL slots; a frame is exactly VTOTAL lines.

Raw (undelayed) timing:
- hsync active iff HRES+HFRONT <= hcount < HRES+HFRONT+HSYNC.
- vsync active iff VRES+VFRONT <= vcount < VRES+VFRONT+VSYNC.
- visible iff hcount < HRES && vcount < VRES.

Address generation (no multiplier):
- row_base register; mem_add = row_base + (hcount >> HSCALE), registered.
- At the h wrap, when vcount[VSCALE-1:0] is all ones (always true if VSCALE = 0), row_base += HRES >> HSCALE.
- At the v wrap, row_base = 0.
- Outside the visible area, mem_add holds its last visible value.

Delay line:
- Raw hsync/vsync/visible pass through MEM_LAT pix_ce-qualified stages.
- MEM_LAT = 0 means registered outputs only.

Pulses:
- line_start and frame_start are asserted for one clock, and only on a pix_ce clock.

Reset:
- hcount = 0, vcount = 0, row_base = 0, mem_add = 0.
- Delay line flushed to sync-inactive, blank = 0.
- Outputs inactive: vga_hsync = ~HSYNC_POL, vga_vsync = ~VSYNC_POL, vga_blank = 0, pulses = 0.
- Reset mid-frame takes effect on the next edge regardless of pix_ce.
- The first pix_ce after reset emits frame_start.

Optional Feature:
VGA_FRAME_COUNT_EN
- Defined: adds output frame_count [15:0]. Reset value 0. Increments on each frame_start and wraps at 0xFFFF -> 0.
- Undefined: the port is absent and no counter logic is present.

Decomposition:
- Package vga_pkg holds timing constants for the 640x480@60 preset, an htotal/vtotal helper function, and the polarity constants.
- One natural sub-module: vga_delay_line, a parametrised depth/width pix_ce-qualified shift register, reused for sync/blank.

Test Plan:
1. Defaults, pix_ce = 1, after reset → hsync low exactly for hcount 656..751; line period 800 clocks; frame period 525 lines; vsync low for lines 490..491.
2. Defaults, MEM_LAT = 1 → vga_blank first goes 1 one clock after mem_add = 0; mem_add at the last visible pixel = 307199.
3. HSCALE = 1, VSCALE = 1 → mem_add repeats each value twice per line; lines 0 and 1 start at 0, line 2 starts at 320; final address 76799.
4. pix_ce toggling 1/0 → line period 1600 clocks; outputs identical to scenario 1 when sampled on pix_ce.
5. Reset asserted at vcount = 200 with pix_ce = 0 → next clock: counters 0, hsync/vsync inactive, blank 0; frame_start on the first pix_ce after release.
6. HSYNC_POL = 1, VSYNC_POL = 1, with VGA_FRAME_COUNT_EN → syncs active-high; frame_count = 3 after 3 frames.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing preset, sync polarity codes and line/frame total helper
package vga_pkg;
  localparam bit POL_LOW = 1'b0;
  localparam bit POL_HIGH = 1'b1;
  localparam int H_RES = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_RES = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  function automatic int vga_total(input int res, input int front, input int sync, input int back);
    return res + front + sync + back;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage clock-enabled shift register with a reset flush value
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clock)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
    end else if (ce) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/blank/frame-buffer address generator; VGA_FRAME_COUNT_EN adds frame_count
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HRES = H_RES,
  parameter int HFRONT = H_FRONT,
  parameter int HSYNC = H_SYNC,
  parameter int HBACK = H_BACK,
  parameter int VRES = V_RES,
  parameter int VFRONT = V_FRONT,
  parameter int VSYNC = V_SYNC,
  parameter int VBACK = V_BACK,
  parameter bit HSYNC_POL = POL_LOW,
  parameter bit VSYNC_POL = POL_LOW,
  parameter int HSCALE = 0,
  parameter int VSCALE = 0,
  parameter int MEM_LAT = 1,
  parameter int ADDR_W = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pix_ce,
`ifdef VGA_FRAME_COUNT_EN
  output logic [15:0]       frame_count,
`endif
  output logic [ADDR_W-1:0] mem_add,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_blank,
  output logic              vga_sync,
  output logic              line_start,
  output logic              frame_start
);
  localparam int HTOTAL = vga_total(HRES, HFRONT, HSYNC, HBACK);
  localparam int VTOTAL = vga_total(VRES, VFRONT, VSYNC, VBACK);
  localparam int HW = $clog2(HTOTAL + 1);
  localparam int VW = $clog2(VTOTAL + 1);
  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_VIS = HW'(HRES);
  localparam logic [HW-1:0] H_SON = HW'(HRES + HFRONT);
  localparam logic [HW-1:0] H_SOFF = HW'(HRES + HFRONT + HSYNC);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_VIS = VW'(VRES);
  localparam logic [VW-1:0] V_SON = VW'(VRES + VFRONT);
  localparam logic [VW-1:0] V_SOFF = VW'(VRES + VFRONT + VSYNC);
  localparam logic [VW-1:0] V_MASK = VW'((1 << VSCALE) - 1);
  localparam logic [ADDR_W-1:0] ROW_INC = ADDR_W'(HRES >> HSCALE);
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [ADDR_W-1:0] row_base;
  logic h_wrap, v_wrap, v_last, visible, hs_act, vs_act;
  assign h_wrap = hcount == H_LAST;
  assign v_wrap = vcount == V_LAST;
  assign v_last = (vcount & V_MASK) == V_MASK;
  assign visible = hcount < H_VIS && vcount < V_VIS;
  assign hs_act = hcount >= H_SON && hcount < H_SOFF;
  assign vs_act = vcount >= V_SON && vcount < V_SOFF;
  assign line_start = pix_ce && !reset && hcount == '0;
  assign frame_start = line_start && vcount == '0;
  assign vga_sync = 1'b0;
  always_ff @(posedge clock)
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
      row_base <= '0;
      mem_add <= '0;
    end else if (pix_ce) begin
      hcount <= h_wrap ? '0 : hcount + 1'b1;
      if (h_wrap) begin
        vcount <= v_wrap ? '0 : vcount + 1'b1;
        row_base <= v_wrap ? '0 : v_last ? row_base + ROW_INC : row_base;
      end
      if (visible) mem_add <= row_base + ADDR_W'(hcount >> HSCALE);
    end
  vga_delay_line #(
    .DEPTH(MEM_LAT + 1),
    .WIDTH(3),
    .RST_VAL({~HSYNC_POL, ~VSYNC_POL, 1'b0})
  ) u_dly (
    .clock(clock),
    .reset(reset),
    .ce(pix_ce),
    .d({hs_act ^ ~HSYNC_POL, vs_act ^ ~VSYNC_POL, visible}),
    .q({vga_hsync, vga_vsync, vga_blank})
  );
`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clock)
    if (reset) frame_count <= '0;
    else if (frame_start) frame_count <= frame_count + 1'b1;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default, small MEM_LAT=1 and scaled active-high timing generators
module tb_vga_timing_gen;
  logic clock = 1'b0, reset = 1'b1, pix_ce = 1'b0;
  always #5 clock = ~clock;
  logic [18:0] a_mem;
  logic [7:0] b_mem, c_mem;
  logic a_hs, a_vs, a_bl, a_sy, a_ls, a_fs;
  logic b_hs, b_vs, b_bl, b_sy, b_ls, b_fs;
  logic c_hs, c_vs, c_bl, c_sy, c_ls, c_fs;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] a_fc, b_fc, c_fc;
`endif
  vga_timing_gen u_a (
    .clock(clock), .reset(reset), .pix_ce(pix_ce),
`ifdef VGA_FRAME_COUNT_EN
    .frame_count(a_fc),
`endif
    .mem_add(a_mem), .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_blank(a_bl),
    .vga_sync(a_sy), .line_start(a_ls), .frame_start(a_fs)
  );
  vga_timing_gen #(
    .HRES(8), .HFRONT(2), .HSYNC(3), .HBACK(1), .VRES(6), .VFRONT(1), .VSYNC(2), .VBACK(1),
    .MEM_LAT(1), .ADDR_W(8)
  ) u_b (
    .clock(clock), .reset(reset), .pix_ce(pix_ce),
`ifdef VGA_FRAME_COUNT_EN
    .frame_count(b_fc),
`endif
    .mem_add(b_mem), .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_blank(b_bl),
    .vga_sync(b_sy), .line_start(b_ls), .frame_start(b_fs)
  );
  vga_timing_gen #(
    .HRES(8), .HFRONT(2), .HSYNC(3), .HBACK(1), .VRES(6), .VFRONT(1), .VSYNC(2), .VBACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .HSCALE(1), .VSCALE(1), .MEM_LAT(0), .ADDR_W(8)
  ) u_c (
    .clock(clock), .reset(reset), .pix_ce(pix_ce),
`ifdef VGA_FRAME_COUNT_EN
    .frame_count(c_fc),
`endif
    .mem_add(c_mem), .vga_hsync(c_hs), .vga_vsync(c_vs), .vga_blank(c_bl),
    .vga_sync(c_sy), .line_start(c_ls), .frame_start(c_fs)
  );
  int cyc = 0, a_ls_now = 0, a_ls_prev = 0, b_ls_now = 0, b_ls_prev = 0, b_fs_now = 0, b_fs_prev = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (a_ls) begin a_ls_prev <= a_ls_now; a_ls_now <= cyc; end
    if (b_ls) begin b_ls_prev <= b_ls_now; b_ls_now <= cyc; end
    if (b_fs) begin b_fs_prev <= b_fs_now; b_fs_now <= cyc; end
  end
  int n_chk = 0, n_fail = 0, k = 0;
  bit toggle = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (slot %0d)", tag, got, exp, k);
    end
  endtask
  task automatic slot();
    if (toggle) begin
      pix_ce = 1'b0;
      @(posedge clock); #1;
      pix_ce = 1'b1;
    end
    @(posedge clock); #1;
    k++;
  endtask
  task automatic run_to(input int n);
    while (k < n) slot();
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("b_hs_rst", 32'(b_hs), 1); chk("b_vs_rst", 32'(b_vs), 1); chk("b_bl_rst", 32'(b_bl), 0);
    chk("b_mem_rst", 32'(b_mem), 0); chk("b_fs_rst", 32'(b_fs), 0); chk("a_vs_rst", 32'(a_vs), 1);
    chk("c_hs_rst", 32'(c_hs), 0); chk("c_vs_rst", 32'(c_vs), 0);
    chk("a_sync", 32'(a_sy), 0); chk("b_sync", 32'(b_sy), 0); chk("c_sync", 32'(c_sy), 0);
    reset = 1'b0; pix_ce = 1'b1; #1;
    chk("b_fs0", 32'(b_fs), 1); chk("b_ls0", 32'(b_ls), 1); chk("a_fs0", 32'(a_fs), 1);
    chk("c_fs0", 32'(c_fs), 1); chk("c_ls0", 32'(c_ls), 1);
    run_to(1);
    chk("b_mem1", 32'(b_mem), 0); chk("b_bl1", 32'(b_bl), 0); chk("b_fs1", 32'(b_fs), 0);
    chk("c_bl1", 32'(c_bl), 1); chk("c_mem1", 32'(c_mem), 0);
`ifdef VGA_FRAME_COUNT_EN
    chk("a_fc1", 32'(a_fc), 1); chk("b_fc1", 32'(b_fc), 1); chk("c_fc1", 32'(c_fc), 1);
`endif
    run_to(2);
    chk("b_bl2", 32'(b_bl), 1); chk("b_mem2", 32'(b_mem), 1); chk("a_bl2", 32'(a_bl), 1);
    chk("a_mem2", 32'(a_mem), 1); chk("c_mem2", 32'(c_mem), 0);
    run_to(3);  chk("c_mem3", 32'(c_mem), 1);
    run_to(9);  chk("b_mem9", 32'(b_mem), 7);
    run_to(10); chk("b_bl10", 32'(b_bl), 0); chk("b_mem10", 32'(b_mem), 7); chk("c_hs10", 32'(c_hs), 0);
    run_to(11); chk("b_hs11", 32'(b_hs), 1); chk("c_hs11", 32'(c_hs), 1);
    run_to(12); chk("b_hs12", 32'(b_hs), 0);
    run_to(14);
    chk("b_hs14", 32'(b_hs), 0); chk("b_ls14", 32'(b_ls), 1); chk("b_fs14", 32'(b_fs), 0); chk("c_hs14", 32'(c_hs), 0);
    run_to(15); chk("b_hs15", 32'(b_hs), 1); chk("c_mem15", 32'(c_mem), 0);
    run_to(16); chk("b_bl16", 32'(b_bl), 1); chk("b_mem16", 32'(b_mem), 9);
    run_to(29); chk("c_mem29", 32'(c_mem), 4);
    run_to(78); chk("b_mem_last", 32'(b_mem), 47); chk("c_mem_last", 32'(c_mem), 11);
    run_to(98); chk("c_vs98", 32'(c_vs), 0);
    run_to(99); chk("b_vs99", 32'(b_vs), 1); chk("c_vs99", 32'(c_vs), 1);
    run_to(100); chk("b_vs100", 32'(b_vs), 0);
    run_to(126); chk("c_vs126", 32'(c_vs), 1);
    run_to(127); chk("b_vs127", 32'(b_vs), 0); chk("c_vs127", 32'(c_vs), 0);
    run_to(128); chk("b_vs128", 32'(b_vs), 1);
    run_to(139); chk("b_mem139", 32'(b_mem), 47);
    run_to(140); chk("b_fs140", 32'(b_fs), 1);
    run_to(141);
    chk("b_mem141", 32'(b_mem), 0);
    chk("b_line_per", 32'(b_ls_now - b_ls_prev), 14);
    chk("b_frame_per", 32'(b_fs_now - b_fs_prev), 140);
`ifdef VGA_FRAME_COUNT_EN
    run_to(281); chk("c_fc3", 32'(c_fc), 3);
`endif
    run_to(641); chk("a_mem641", 32'(a_mem), 639); chk("a_bl641", 32'(a_bl), 1);
    run_to(642); chk("a_bl642", 32'(a_bl), 0);
    run_to(657); chk("a_hs657", 32'(a_hs), 1);
    run_to(658); chk("a_hs658", 32'(a_hs), 0);
    run_to(700); chk("a_mem700", 32'(a_mem), 639);
    run_to(753); chk("a_hs753", 32'(a_hs), 0);
    run_to(754); chk("a_hs754", 32'(a_hs), 1);
    run_to(801);
    chk("a_line_per", 32'(a_ls_now - a_ls_prev), 800);
    chk("b_vs_pre", 32'(b_vs), 0); chk("c_vs_pre", 32'(c_vs), 1); chk("b_mem_pre", 32'(b_mem), 47);
    pix_ce = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; #1;
    chk("b_vs_mrst", 32'(b_vs), 1); chk("b_hs_mrst", 32'(b_hs), 1); chk("b_bl_mrst", 32'(b_bl), 0);
    chk("b_mem_mrst", 32'(b_mem), 0); chk("c_vs_mrst", 32'(c_vs), 0); chk("b_fs_noce", 32'(b_fs), 0);
    k = 0; toggle = 1'b1; pix_ce = 1'b1; #1;
    chk("b_fs_rel", 32'(b_fs), 1);
    run_to(2);  chk("t_b_bl2", 32'(b_bl), 1); chk("t_b_mem2", 32'(b_mem), 1);
    run_to(11); chk("t_b_hs11", 32'(b_hs), 1);
    run_to(12); chk("t_b_hs12", 32'(b_hs), 0);
    run_to(14);
    chk("t_b_ls14", 32'(b_ls), 1);
    pix_ce = 1'b0; #1;
    chk("t_b_ls_gated", 32'(b_ls), 0);
    run_to(16); chk("t_b_mem16", 32'(b_mem), 9);
    run_to(30); chk("t_b_line_per", 32'(b_ls_now - b_ls_prev), 28);
    run_to(801); chk("t_a_line_per", 32'(a_ls_now - a_ls_prev), 1600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
